// File: rtl/xaui_tx_fifo_pkg.sv
// Shared constants and helpers for the XAUI transmit FIFO.
package xaui_tx_fifo_pkg;

   localparam bit [0:0]    STAT_ALMOST       = 1'b0;
   localparam bit [0:0]    STAT_FULL_EMPTY   = 1'b1;
   localparam int unsigned DEF_DEPTH_LOG2    = 9;
   localparam int unsigned DEF_AFULL_THRESH  = 448;
   localparam int unsigned DEF_AEMPTY_THRESH = 1;
   localparam int unsigned ERR_CNT_W         = 16;
   localparam int unsigned DATA_W            = 64;

   // Saturating error-counter update; a clear wins over an increment.
   function automatic logic [ERR_CNT_W-1:0] err_next(input logic [ERR_CNT_W-1:0] cur,
                                                     input logic inc, input logic clr);
      if (clr) return '0;
      if (inc && (cur != '1)) return cur + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
      return cur;
   endfunction

endpackage

// File: rtl/xaui_fifo_ram.sv
// Simple dual-port RAM, synchronous write and synchronous read, no reset on contents.
module xaui_fifo_ram #(
   parameter int unsigned ADDR_W = 9,
   parameter int unsigned WIDTH  = 64
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [WIDTH-1:0]  rdata
);

   logic [WIDTH-1:0] mem [0:(1<<ADDR_W)-1];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/xaui_tx_fifo.sv
// First-word-fall-through transmit FIFO with registered status and saturating error counters.
module xaui_tx_fifo
   import xaui_tx_fifo_pkg::*;
#(
   parameter int unsigned DEPTH_LOG2    = DEF_DEPTH_LOG2,
   parameter int unsigned AFULL_THRESH  = DEF_AFULL_THRESH,
   parameter int unsigned AEMPTY_THRESH = DEF_AEMPTY_THRESH
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 wr_en,
   input  logic [DATA_W-1:0]    wr_data,
   input  logic                 rd_en,
   output logic [DATA_W-1:0]    rd_data,
   output logic [1:0]           wr_status,
   output logic [1:0]           rd_status,
   output logic [DEPTH_LOG2:0]  count,
   input  logic                 err_clr,
   output logic [ERR_CNT_W-1:0] overflow_cnt,
   output logic [ERR_CNT_W-1:0] underflow_cnt
);

   localparam logic [DEPTH_LOG2:0]   FULL_CNT   = {1'b1, {DEPTH_LOG2{1'b0}}};
   localparam logic [DEPTH_LOG2:0]   CNT_ONE    = {{DEPTH_LOG2{1'b0}}, 1'b1};
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
   localparam logic [DEPTH_LOG2:0]   AFULL_CNT  = AFULL_THRESH[DEPTH_LOG2:0];
   localparam logic [DEPTH_LOG2:0]   AEMPTY_CNT = AEMPTY_THRESH[DEPTH_LOG2:0];

   logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
   logic [DEPTH_LOG2:0]   count_d;
   logic                  full, empty, wr_acc, rd_acc, ram_re;
   logic [DATA_W-1:0]     ram_rdata, bypass_q;
   logic                  use_bypass_q;

   always_comb begin
      full       = (count == FULL_CNT);
      empty      = (count == '0);
      wr_acc     = reset & wr_en & ~full;
      rd_acc     = reset & rd_en & ~empty;
      rd_ptr_nxt = rd_acc ? rd_ptr + PTR_ONE : rd_ptr;
      unique case ({wr_acc, rd_acc})
         2'b10:   count_d = count + CNT_ONE;
         2'b01:   count_d = count - CNT_ONE;
         default: count_d = count;
      endcase
      // Prefetch the next head so it is on the output right after the edge.
      ram_re = reset & (count_d != '0);
   end

   xaui_fifo_ram #(
      .ADDR_W (DEPTH_LOG2),
      .WIDTH  (DATA_W)
   ) u_ram (
      .clk   (clk),
      .we    (wr_acc),
      .waddr (wr_ptr),
      .wdata (wr_data),
      .re    (ram_re),
      .raddr (rd_ptr_nxt),
      .rdata (ram_rdata)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         count         <= '0;
         wr_status     <= 2'b00;
         rd_status     <= 2'b11;
         overflow_cnt  <= '0;
         underflow_cnt <= '0;
         bypass_q      <= '0;
         use_bypass_q  <= 1'b1;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
         rd_ptr                     <= rd_ptr_nxt;
         count                      <= count_d;
         wr_status[STAT_ALMOST]     <= (count_d >= AFULL_CNT);
         wr_status[STAT_FULL_EMPTY] <= (count_d == FULL_CNT);
         rd_status[STAT_ALMOST]     <= (count_d <= AEMPTY_CNT);
         rd_status[STAT_FULL_EMPTY] <= (count_d == '0);
         overflow_cnt  <= err_next(overflow_cnt, wr_en & full, err_clr);
         underflow_cnt <= err_next(underflow_cnt, rd_en & empty, err_clr);
         // The RAM read misses a word written on the same edge into the head slot.
         if (count_d != '0) begin
            use_bypass_q <= wr_acc & (wr_ptr == rd_ptr_nxt);
            bypass_q     <= wr_data;
         end
      end
   end

   assign rd_data = use_bypass_q ? bypass_q : ram_rdata;

endmodule
